wishbone_arbitrator: RTL and testbench
======================================

Name: wishbone_arbitrator

Overview:
- Upstream neighbour of the Wishbone address decoder.
- Multiplexes NUM_MANAGERS Wishbone managers (e.g. Caravel management core, on-chip debug/UART bridge, DMA) onto the single manager-side bus the decoder consumes.
- Uses registered round-robin arbitration with grant locking for the whole cyc period.
- Routes the decoder's ack/dat back only to the granted manager.

Parameters:
- NUM_MANAGERS, 3, number of upstream Wishbone managers (>=2).
- TIMEOUT_CYCLES, 255, cycles a granted transfer may wait for ack; used only when WB_ARB_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- wbs_cyc_i_mgr  input  [NUM_MANAGERS-1:0]  per-manager cycle request.
- wbs_stb_i_mgr  input  [NUM_MANAGERS-1:0]  per-manager strobe.
- wbs_we_i_mgr  input  [NUM_MANAGERS-1:0]  per-manager write enable.
- wbs_adr_i_mgr  input  [NUM_MANAGERS-1:0][31:0]  per-manager address.
- wbs_dat_i_mgr  input  [NUM_MANAGERS-1:0][31:0]  per-manager write data.
- wbs_sel_i_mgr  input  [NUM_MANAGERS-1:0][3:0]  per-manager byte select.
- wbs_ack_o_mgr  output  [NUM_MANAGERS-1:0]  ack returned to each manager.
- wbs_dat_o_mgr  output  [NUM_MANAGERS-1:0][31:0]  read data returned to each manager.
- wbs_cyc_o_m, wbs_stb_o_m, wbs_we_o_m  output  1 each  to decoder.
- wbs_adr_o_m, wbs_dat_o_m  output  32 each  to decoder.
- wbs_sel_o_m  output  4  to decoder.
- wbs_ack_i_m  input  1  ack from decoder.
- wbs_dat_i_m  input  32  read data from decoder.
- grant_o  output  [NUM_MANAGERS-1:0]  one-hot current grant (zero when idle), for debug/LA.

Behaviour:
- Reset (nRST low, async):
  - state=IDLE, grant=0, last_grant=NUM_MANAGERS-1 so manager 0 wins the first arbitration.
  - All outputs 0 while in reset and the cycle after release.
- FSM states IDLE, GRANTED, RELEASE.
- IDLE:
  - All decoder-side outputs 0; all wbs_ack_o_mgr/wbs_dat_o_mgr 0.
  - If any wbs_cyc_i_mgr is high, pick the first requester searching upward from last_grant+1, wrapping modulo NUM_MANAGERS.
  - Register the one-hot grant and go to GRANTED.
  - Latency: request seen at edge N, forwarded to the decoder from cycle N+1.
- GRANTED:
  - cyc/stb/we/adr/dat/sel of the granted manager drive the decoder outputs combinationally.
  - wbs_ack_i_m/wbs_dat_i_m are steered to the granted index; every other manager sees ack=0 and dat=0.
  - Grant is locked while the granted cyc stays high, through multiple stb/ack beats; requests from other managers are ignored.
  - Granted cyc falling → go to RELEASE and set last_grant to the granted index.
- RELEASE:
  - One cycle with all decoder outputs 0, which guarantees the decoder sees a cyc-low gap and returns to its idle state.
  - Then go to IDLE.
- Boundaries:
  - Simultaneous requests are resolved purely by round-robin order.
  - A manager whose cyc drops before its grant registers is ignored; the grant re-evaluates in IDLE.
  - An ack arriving in IDLE or RELEASE is discarded.
  - The same manager re-requesting immediately loses to any other pending requester.
  - Reset mid-transfer aborts without ack.
- Throughput: minimum 3 cycles per cyc period (grant, ≥1 transfer, release).

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on grant and on every wbs_ack_i_m.
  - It counts while GRANTED with stb high.
  - On reaching TIMEOUT_CYCLES, the arbitrator drives a one-cycle ack to the granted manager with dat=32'hBAD0_BAD0, deasserts decoder cyc/stb, and goes to RELEASE.
  - Any further ack from the decoder for that transfer is dropped.
- When undefined: no counter exists; the grant waits forever.

Decomposition:
- Package wb_arb_pkg holds:
  - arb_state_t enum (IDLE, GRANTED, RELEASE).
  - WB_ARB_TIMEOUT_DATA = 32'hBAD0_BAD0.
  - Default NUM_MANAGERS.
- One sub-module, rr_priority_picker: a combinational round-robin one-hot selector taking req and last_grant and producing a one-hot grant. It is reusable and testable alone.

Test Plan:
- Single manager 1 writes adr 32'h3000_0004 dat 32'h1234_5678 → grant_o=3'b010 one cycle later; decoder outputs mirror manager 1; decoder ack returns only on wbs_ack_o_mgr[1].
- Managers 0 and 2 request together after reset → manager 0 served first; after its cyc drops and a 1-cycle gap, grant_o=3'b100.
- All three request continuously for 6 cyc periods → grant order 0,1,2,0,1,2, with one RELEASE cycle between each.
- Manager 0 holds cyc over 3 stb/ack beats while manager 1 requests → grant stays 3'b001 until manager 0 drops cyc; decoder read dat 32'hCAFE_F00D appears only on wbs_dat_o_mgr[0].
- nRST asserted while GRANTED → all outputs 0 immediately; after release, manager 0 has priority again.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, decoder never acks → at the 8th waiting cycle the granted manager gets ack=1 with dat 32'hBAD0_BAD0, then the FSM goes to RELEASE and then IDLE.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone manager arbitrator.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic [31:0] WB_ARB_TIMEOUT_DATA  = 32'hBAD0_BAD0;
  localparam int          DEFAULT_NUM_MANAGERS = 3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin selector: first requester above last_grant, wrapping.
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbitrator.sv
// Round-robin Wishbone arbitrator: N managers onto one decoder-facing bus, grant locked per cyc.
// Optional WB_ARB_TIMEOUT_EN: abort a stalled transfer with a synthetic ack after TIMEOUT_CYCLES.
module wishbone_arbitrator
  import wb_arb_pkg::*;
#(
  parameter int NUM_MANAGERS   = DEFAULT_NUM_MANAGERS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_MANAGERS-1:0]      wbs_cyc_i_mgr,
  input  logic [NUM_MANAGERS-1:0]      wbs_stb_i_mgr,
  input  logic [NUM_MANAGERS-1:0]      wbs_we_i_mgr,
  input  logic [NUM_MANAGERS-1:0][31:0] wbs_adr_i_mgr,
  input  logic [NUM_MANAGERS-1:0][31:0] wbs_dat_i_mgr,
  input  logic [NUM_MANAGERS-1:0][3:0]  wbs_sel_i_mgr,
  output logic [NUM_MANAGERS-1:0]      wbs_ack_o_mgr,
  output logic [NUM_MANAGERS-1:0][31:0] wbs_dat_o_mgr,
  output logic                         wbs_cyc_o_m,
  output logic                         wbs_stb_o_m,
  output logic                         wbs_we_o_m,
  output logic [31:0]                  wbs_adr_o_m,
  output logic [31:0]                  wbs_dat_o_m,
  output logic [3:0]                   wbs_sel_o_m,
  input  logic                         wbs_ack_i_m,
  input  logic [31:0]                  wbs_dat_i_m,
  output logic [NUM_MANAGERS-1:0]      grant_o
);

  localparam int IDX_W = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;

  if (NUM_MANAGERS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wishbone_arbitrator: NUM_MANAGERS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t              state, state_nxt;
  logic [NUM_MANAGERS-1:0] grant, grant_nxt, pick;
  logic [IDX_W-1:0]        last_grant, last_grant_nxt, gidx;
  logic                    timeout_hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_MANAGERS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (wbs_cyc_i_mgr),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MANAGERS; i++) begin
      if (grant[i]) gidx = IDX_W'(i);
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Fires on the TIMEOUT_CYCLES-th strobed cycle without an ack.
  assign timeout_hit = (state == GRANTED) && wbs_stb_i_mgr[gidx] && !wbs_ack_i_m &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      to_cnt <= '0;
    end else if (state != GRANTED || wbs_ack_i_m) begin
      to_cnt <= '0;
    end else if (wbs_stb_i_mgr[gidx]) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_MANAGERS - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (|wbs_cyc_i_mgr) begin
          grant_nxt = pick;
          state_nxt = GRANTED;
        end
      end
      GRANTED: begin
        if (!wbs_cyc_i_mgr[gidx] || timeout_hit) begin
          grant_nxt      = '0;
          last_grant_nxt = gidx;
          state_nxt      = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- bus steering ----
  always_comb begin
    wbs_cyc_o_m   = 1'b0;
    wbs_stb_o_m   = 1'b0;
    wbs_we_o_m    = 1'b0;
    wbs_adr_o_m   = '0;
    wbs_dat_o_m   = '0;
    wbs_sel_o_m   = '0;
    wbs_ack_o_mgr = '0;
    wbs_dat_o_mgr = '0;
    if (state == GRANTED) begin
      wbs_cyc_o_m         = wbs_cyc_i_mgr[gidx] && !timeout_hit;
      wbs_stb_o_m         = wbs_stb_i_mgr[gidx] && !timeout_hit;
      wbs_we_o_m          = wbs_we_i_mgr[gidx];
      wbs_adr_o_m         = wbs_adr_i_mgr[gidx];
      wbs_dat_o_m         = wbs_dat_i_mgr[gidx];
      wbs_sel_o_m         = wbs_sel_i_mgr[gidx];
      wbs_ack_o_mgr[gidx] = wbs_ack_i_m || timeout_hit;
      wbs_dat_o_mgr[gidx] = timeout_hit ? WB_ARB_TIMEOUT_DATA : wbs_dat_i_m;
    end
  end

  assign grant_o = grant;

endmodule

// File: tb/tb_wishbone_arbitrator.sv
// Bench for wishbone_arbitrator: directed scenarios plus random traffic against an owner/cooldown model.
module tb_wishbone_arbitrator;

  localparam int N  = 3;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             nRST;
  logic [N-1:0]     cyc_i, stb_i, we_i;
  logic [N-1:0][31:0] adr_i, dat_i;
  logic [N-1:0][3:0]  sel_i;
  logic [N-1:0]     ack_o;
  logic [N-1:0][31:0] dato;
  logic             cyc_o, stb_o, we_o;
  logic [31:0]      adr_o, dat_o_m;
  logic [3:0]       sel_o;
  logic             ack_m;
  logic [31:0]      dat_m;
  logic [N-1:0]     grant_o;

  int n_vec = 0;
  int n_err = 0;

  wishbone_arbitrator #(.NUM_MANAGERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .wbs_cyc_i_mgr (cyc_i),
    .wbs_stb_i_mgr (stb_i),
    .wbs_we_i_mgr  (we_i),
    .wbs_adr_i_mgr (adr_i),
    .wbs_dat_i_mgr (dat_i),
    .wbs_sel_i_mgr (sel_i),
    .wbs_ack_o_mgr (ack_o),
    .wbs_dat_o_mgr (dato),
    .wbs_cyc_o_m   (cyc_o),
    .wbs_stb_o_m   (stb_o),
    .wbs_we_o_m    (we_o),
    .wbs_adr_o_m   (adr_o),
    .wbs_dat_o_m   (dat_o_m),
    .wbs_sel_o_m   (sel_o),
    .wbs_ack_i_m   (ack_m),
    .wbs_dat_i_m   (dat_m),
    .grant_o       (grant_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: which manager owns the bus, how many dead cycles remain
  // before arbitration resumes, who was served last, and how long the owner waited.
  int owner, cooldown, last, waitc, c_idx;
  logic             e_cyc, e_stb, e_we;
  logic [31:0]      e_adr, e_dat;
  logic [3:0]       e_sel;
  logic [N-1:0]     e_grant, e_ack;
  logic [N-1:0][31:0] e_dm;
  bit               to_fire;

  initial begin
    owner = -1; cooldown = 0; last = N - 1; waitc = 0;
    forever begin
      @(negedge CLK);
      e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
      e_grant = '0; e_ack = '0; e_dm = '0; to_fire = 0;
      if (!nRST) begin
        owner = -1; cooldown = 0; last = N - 1; waitc = 0;
      end else if (owner >= 0) begin
        to_fire = TO_EN && stb_i[owner] && !ack_m && (waitc == TO - 1);
        e_cyc = cyc_i[owner] && !to_fire;
        e_stb = stb_i[owner] && !to_fire;
        e_we  = we_i[owner];
        e_adr = adr_i[owner];
        e_dat = dat_i[owner];
        e_sel = sel_i[owner];
        e_grant = N'(1 << owner);
        e_ack[owner] = to_fire ? 1'b1 : ack_m;
        e_dm[owner]  = to_fire ? 32'hBAD0_BAD0 : dat_m;
      end
      check("m_cyc", 128'(cyc_o), 128'(e_cyc));
      check("m_stb", 128'(stb_o), 128'(e_stb));
      check("m_we", 128'(we_o), 128'(e_we));
      check("m_adr", 128'(adr_o), 128'(e_adr));
      check("m_dat", 128'(dat_o_m), 128'(e_dat));
      check("m_sel", 128'(sel_o), 128'(e_sel));
      check("m_grant", 128'(grant_o), 128'(e_grant));
      check("m_ack_mgr", 128'(ack_o), 128'(e_ack));
      check("m_dat_mgr", 128'(dato), 128'(e_dm));
      // advance the model to what the next rising edge produces
      if (nRST) begin
        if (owner >= 0) begin
          if (to_fire || !cyc_i[owner]) begin
            last = owner; owner = -1; cooldown = 1;
          end else if (ack_m) waitc = 0;
          else if (stb_i[owner]) waitc++;
        end else if (cooldown > 0) begin
          cooldown--;
        end else begin
          for (int k = 1; k <= N; k++) begin
            c_idx = (last + k) % N;
            if (owner < 0 && cyc_i[c_idx]) owner = c_idx;
          end
          waitc = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input string name);
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (grant_o != '0) break;
    end
    check(name, 128'(grant_o), 128'(exp));
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    step(2);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; cyc_i = '0; stb_i = '0; we_i = '0;
    adr_i = '0; dat_i = '0; sel_i = '0; ack_m = 1'b0; dat_m = '0;
    step(2);
    check("rst_grant", 128'(grant_o), 128'(3'b000));
    check("rst_cyc", 128'(cyc_o), 128'(1'b0));
    check("rst_ack", 128'(ack_o), 128'(3'b000));
    nRST = 1'b1;

    // single manager 1 write
    cyc_i[1] = 1; stb_i[1] = 1; we_i[1] = 1; sel_i[1] = 4'hF;
    adr_i[1] = 32'h3000_0004; dat_i[1] = 32'h1234_5678;
    #1 check("idle_grant", 128'(grant_o), 128'(3'b000));
    step(1);
    check("w_grant", 128'(grant_o), 128'(3'b010));
    check("w_adr", 128'(adr_o), 128'(32'h3000_0004));
    check("w_dat", 128'(dat_o_m), 128'(32'h1234_5678));
    check("w_we", 128'(we_o), 128'(1'b1));
    ack_m = 1;
    #1 check("w_ack", 128'(ack_o), 128'(3'b010));
    step(1);
    ack_m = 0; cyc_i[1] = 0; stb_i[1] = 0;
    step(1);
    check("w_release", 128'(grant_o), 128'(3'b000));
    step(2);

    // managers 0 and 2 after reset
    do_reset();
    cyc_i[0] = 1; cyc_i[2] = 1;
    wait_grant(3'b001, "rr_first0");
    step(1);
    cyc_i[0] = 0;
    step(1);
    check("rr_gap", 128'(grant_o), 128'(3'b000));
    wait_grant(3'b100, "rr_then2");
    cyc_i[2] = 0;
    step(3);

    // six back-to-back periods
    cyc_i = 3'b111; stb_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_grant(N'(1 << (k % N)), $sformatf("rr_order%0d", k));
      cyc_i[k % N] = 0; stb_i[k % N] = 0;
      step(1);
      check($sformatf("rr_rel%0d", k), 128'(grant_o), 128'(3'b000));
      cyc_i[k % N] = 1; stb_i[k % N] = 1;
    end
    cyc_i = '0; stb_i = '0;
    step(3);

    // grant lock over three read beats
    cyc_i = 3'b011; stb_i = 3'b011; we_i = '0;
    wait_grant(3'b001, "lock_grant");
    for (int b = 0; b < 3; b++) begin
      ack_m = 1; dat_m = 32'hCAFE_F00D;
      #1;
      check($sformatf("lock_g%0d", b), 128'(grant_o), 128'(3'b001));
      check($sformatf("lock_ack%0d", b), 128'(ack_o), 128'(3'b001));
      check($sformatf("lock_d0_%0d", b), 128'(dato[0]), 128'(32'hCAFE_F00D));
      check($sformatf("lock_d1_%0d", b), 128'(dato[1]), 128'(32'h0));
      step(1);
    end
    ack_m = 0; cyc_i[0] = 0; stb_i[0] = 0;
    wait_grant(3'b010, "lock_next1");
    cyc_i = '0; stb_i = '0;
    step(3);

    // reset while granted
    cyc_i[2] = 1; stb_i[2] = 1;
    wait_grant(3'b100, "abort_grant");
    ack_m = 1; nRST = 0;
    #1;
    check("abort_grant0", 128'(grant_o), 128'(3'b000));
    check("abort_cyc0", 128'(cyc_o), 128'(1'b0));
    check("abort_ack0", 128'(ack_o), 128'(3'b000));
    cyc_i[0] = 1;
    step(2);
    nRST = 1; ack_m = 0;
    wait_grant(3'b001, "abort_prio0");
    cyc_i = '0; stb_i = '0;
    step(3);

    if (TO_EN) begin
      cyc_i[1] = 1; stb_i[1] = 1;
      wait_grant(3'b010, "to_grant");
      for (int w = 1; w < TO; w++) begin
        check($sformatf("to_wait%0d", w), 128'(ack_o), 128'(3'b000));
        step(1);
      end
      check("to_ack", 128'(ack_o), 128'(3'b010));
      check("to_dat", 128'(dato[1]), 128'(32'hBAD0_BAD0));
      check("to_cyc", 128'(cyc_o), 128'(1'b0));
      cyc_i[1] = 0; stb_i[1] = 0;
      step(1);
      check("to_release", 128'(grant_o), 128'(3'b000));
      step(3);
    end

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      @(posedge CLK);
      #1;
      nRST = ($urandom_range(0, 299) != 0);
      for (int m = 0; m < N; m++) begin
        if (cyc_i[m]) begin
          if ($urandom_range(0, 3) == 0) begin cyc_i[m] = 0; stb_i[m] = 0; end
          else stb_i[m] = $urandom_range(0, 1) != 0;
        end else if ($urandom_range(0, 2) == 0) begin
          cyc_i[m] = 1; stb_i[m] = 1;
        end
        we_i[m]  = $urandom_range(0, 1) != 0;
        adr_i[m] = $urandom;
        dat_i[m] = $urandom;
        sel_i[m] = 4'($urandom);
      end
      ack_m = ($urandom_range(0, 2) == 0);
      dat_m = $urandom;
    end
    nRST = 1; cyc_i = '0; stb_i = '0; ack_m = 0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
